// File: rtl/seq_det_param.sv
// seq_det_param: serial detector for a runtime-loadable SEQ_LEN-bit pattern.
// Optional saturating detection counter built only with SEQ_DET_COUNT_EN.
module seq_det_param #(
   parameter int                 SEQ_LEN     = 4,
   parameter logic [SEQ_LEN-1:0] PATTERN_RST = 4'b1011,
   parameter int                 CNT_W       = 8
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic                       seq_in,
   input  logic                       in_valid,
   input  logic                       overlap_en,
   input  logic [SEQ_LEN-1:0]         pattern,
   input  logic                       pattern_load,
   input  logic                       count_clr,
   output logic                       detected,
   output logic [$clog2(SEQ_LEN+1)-1:0] match_len,
   output logic [CNT_W-1:0]           det_count
);

   localparam int              ML_W = $clog2(SEQ_LEN + 1);
   localparam logic [ML_W-1:0] FULL = ML_W'(SEQ_LEN);

   logic [SEQ_LEN-1:0] r_pat;
   logic [SEQ_LEN-1:0] r_hist;
   logic [ML_W-1:0]    r_fill;
   logic               r_det;

   logic [SEQ_LEN-1:0] w_hist_nxt;
   logic [ML_W-1:0]    w_fill_nxt;
   logic               w_accept;
   logic               w_hit;
   logic [ML_W-1:0]    w_len;
   logic               w_ok;

   assign w_accept   = in_valid & ~pattern_load;
   assign w_hist_nxt = {r_hist[SEQ_LEN-2:0], seq_in};
   assign w_fill_nxt = (r_fill == FULL) ? FULL : r_fill + 1'b1;
   assign w_hit      = w_accept && (w_fill_nxt == FULL)
                       && (w_hist_nxt == r_pat);

   // Pattern, history and pulse registers; load wins over a data bit.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_pat  <= PATTERN_RST;
         r_hist <= '0;
         r_fill <= '0;
         r_det  <= 1'b0;
      end else if (pattern_load) begin
         r_pat  <= pattern;
         r_hist <= '0;
         r_fill <= '0;
         r_det  <= 1'b0;
      end else if (in_valid) begin
         r_hist <= w_hist_nxt;
         r_fill <= (w_hit && !overlap_en) ? '0 : w_fill_nxt;
         r_det  <= w_hit;
      end else begin
         r_det  <= 1'b0;
      end
   end

   // Longest pattern prefix that ends the valid part of the history.
   always_comb begin
      w_len = '0;
      w_ok  = 1'b0;
      for (int k = 1; k <= SEQ_LEN; k++) begin
         w_ok = (ML_W'(k) <= r_fill);
         for (int j = 0; j < k; j++) begin
            if (r_hist[j] != r_pat[SEQ_LEN-k+j]) w_ok = 1'b0;
         end
         if (w_ok) w_len = ML_W'(k);
      end
   end

   assign detected  = r_det;
   assign match_len = w_len;

`ifdef SEQ_DET_COUNT_EN
   logic [CNT_W-1:0] r_cnt;

   // Saturating match counter; a clear beats a simultaneous match.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_cnt <= '0;
      end else if (count_clr) begin
         r_cnt <= '0;
      end else if (w_hit && (r_cnt != '1)) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign det_count = r_cnt;
`else
   logic w_unused_clr;

   assign w_unused_clr = count_clr;
   assign det_count    = '0;
`endif

endmodule

// File: doc/seq_det_param.md
# seq_det_param

Parametrised serial sequence detector and the successor to the fixed-pattern non-overlapping FSM detector. It samples one bit per qualified clock and compares the received stream against a runtime-loadable pattern of `SEQ_LEN` bits. Overlapping or non-overlapping detection is selected at runtime. It reports the current prefix-match progress and keeps an optional saturating detection counter. It sits between a serial bit source and control logic that consumes single-cycle `detected` pulses.

## Interface

Parameters:
- `SEQ_LEN`, 4: pattern length in bits; must be ≥ 2.
- `PATTERN_RST`, 4'b1011: pattern loaded at reset, `SEQ_LEN` bits wide.
- `CNT_W`, 8: width of the detection counter.

Ports:
- `clk`  in  1: single clock; all state updates on the rising edge.
- `reset_n`  in  1: asynchronous, active-low reset.
- `seq_in`  in  1: serial data bit.
- `in_valid`  in  1: `seq_in` is sampled only when this is 1.
- `overlap_en`  in  1: 1 = overlapping detection, 0 = non-overlapping.
- `pattern`  in  SEQ_LEN: new pattern; bit `SEQ_LEN-1` is the first bit expected on the wire.
- `pattern_load`  in  1: latch `pattern` and restart matching.
- `count_clr`  in  1: clear `det_count`.
- `detected`  out  1: registered one-cycle pulse per match.
- `match_len`  out  $clog2(SEQ_LEN+1): current prefix-match length, 0..SEQ_LEN.
- `det_count`  out  CNT_W: saturating count of detections.

## Operation

- **Internal state:**
  - `pat_r`: `SEQ_LEN` bits.
  - `hist`: shift register of the last `SEQ_LEN` accepted bits, newest bit in the LSB.
  - `fill`: count of valid history bits, saturating at `SEQ_LEN`.
- **Reset (asynchronous):**
  - `pat_r` = `PATTERN_RST`.
  - `hist` = 0, `fill` = 0.
  - `detected` = 0, `det_count` = 0, so `match_len` = 0.
- **Priority per edge:** reset > `pattern_load` > accepted bit.
- **`pattern_load` = 1:**
  - `pat_r` ← `pattern`; `hist` and `fill` are cleared; `detected` ← 0.
  - `seq_in` is ignored that cycle, even if `in_valid` = 1.
- **Accepted bit** (`in_valid` = 1, no load):
  - `hist` ← {`hist`, `seq_in`}; `fill` ← min(`fill`+1, `SEQ_LEN`).
  - A match occurs when the new `fill` = `SEQ_LEN` and the new `hist` = `pat_r`. The match sets `detected` ← 1.
  - After a match with `overlap_en` = 0, `fill` ← 0, so the next match needs `SEQ_LEN` fresh bits.
  - After a match with `overlap_en` = 1, the history is kept.
- **No accepted bit:** `hist` and `fill` hold; `detected` ← 0.
- **`match_len`:** combinational from registers. It is the largest k ≤ `fill` such that the last k accepted bits equal `pat_r[SEQ_LEN-1 -: k]`; 0 if none.
  - Immediately after an overlap-mode match it equals `SEQ_LEN`.
  - After a non-overlap match it is 0.
- **`overlap_en`:** sampled only on the edge where a match occurs. It may change freely between bits.
- **`det_count`:**
  - Increments on each match and saturates at 2^CNT_W−1.
  - If `count_clr` = 1, it becomes 0 even when a match occurs on the same edge; `detected` still pulses.

## Timing

- **Detection latency:** `detected` is high for the cycle following the rising edge that sampled the final pattern bit.
- **Pulse width:** exactly one cycle, unless the next edge also produces a match. Back-to-back pulses are only possible with `overlap_en` = 1.
- **`match_len` / `det_count`:** update in the same cycle as `detected`.
- **Reset mid-stream:** all outputs go to their reset values immediately (asynchronously). Matching restarts from empty on the first accepted bit after `reset_n` rises.

## Configuration

- **Macro:** `SEQ_DET_COUNT_EN`.
- **Defined:** the `det_count` register and the `count_clr` logic are built as specified.
- **Undefined:**
  - No counter logic is synthesised; `det_count` is tied to 0 and `count_clr` is ignored.
  - All other behaviour is unchanged and the port list is identical.

## Test plan

Unless stated otherwise: `SEQ_LEN`=4, pattern 1011, `in_valid`=1 every cycle, `SEQ_DET_COUNT_EN` defined.

1. **Reset:** hold `reset_n`=0 for 2.5 cycles, then drive 1011 → during reset `detected`=0, `match_len`=0, `det_count`=0; one pulse after the 4th bit; `det_count`=1.
2. **Overlap mode:** drive 1011011 with `overlap_en`=0 → one pulse, after bit 4; final `match_len`=1. Repeat with `overlap_en`=1 → pulses after bits 4 and 7; `det_count`=2.
3. **Back-to-back pulses:** load pattern 1111, `overlap_en`=1, drive six 1s → `detected` high for 3 consecutive cycles; `det_count`=3; `match_len`=4.
4. **Idle gaps:** drive 1,0,1,1 with 2 `in_valid`=0 cycles between each bit → single pulse after the last valid bit; `match_len` holds during gaps.
5. **Load and reset mid-stream:**
   - After 101, pulse `pattern_load` with 0110 and `in_valid`=1 → `match_len`=0; then 0110 → one pulse.
   - Drop `reset_n` after 3 bits → immediate clear.
6. **Counter saturation and clear:**
   - `CNT_W`=2, five matches → `det_count` stays at 3.
   - `count_clr` on the same edge as a match → `det_count`=0 and `detected`=1.
   - Without the macro → `det_count` is always 0.
